// File: rtl/fetch_unit_pkg.sv
// Shared processor package: fetch FSM state type, bubble instruction value
// and the sequential PC increment used by the fetch stage.
package fetch_unit_pkg;

  // FETCH   : request outstanding at pc, result is usable
  // DISCARD : request outstanding at pc, result must be thrown away (redirect pending)
  // HOLD    : word captured while decode stalled; no request outstanding
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DISCARD = 2'd1,
    HOLD    = 2'd2
  } fetch_state_t;

  // Instruction presented to decode on bubbles
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // Byte distance between sequential instructions
  localparam int unsigned PC_INC = 4;

  // A memory request is outstanding in every state except HOLD
  function automatic logic state_requests(input fetch_state_t s);
    return (s != HOLD);
  endfunction

endpackage

// File: rtl/fetch_unit_register.sv
// Generic write-enabled register with synchronous active-high reset.
module fetch_unit_register #(
  parameter int            W         = 32,
  parameter logic [W-1:0]  RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wen,
  input  logic [W-1:0] in,
  output logic [W-1:0] out
);

  // Reset wins over write-enable; otherwise load when enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= RESET_VAL;
    end else if (wen) begin
      out <= in;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives a single-outstanding-request instruction
// memory port, absorbs decode stalls in a one-word hold buffer and handles
// execute-stage redirects, including ones that arrive while a request is
// still in flight (the late response is discarded).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter logic [N-1:0] NOP      = N'(NOP_INST)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_D,
  input  logic         branch_taken_E,
  input  logic [N-1:0] branch_target_E,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [N-1:0] imem_rdata,
  output logic [N-1:0] inst_F,
  output logic [N-1:0] pc_F,
  output logic [N-1:0] pc_plus4_F,
  output logic         valid_F,
  output logic         fetch_busy
);

  fetch_unit_pkg::fetch_state_t r_state;
  fetch_unit_pkg::fetch_state_t w_state_next;

  logic [N-1:0] r_pc;
  logic [N-1:0] r_hold;
  logic [N-1:0] r_redirect;

  logic [N-1:0] w_pc_next;
  logic         w_pc_wen;
  logic [N-1:0] w_hold_next;
  logic         w_hold_wen;
  logic [N-1:0] w_redirect_next;
  logic         w_redirect_wen;

  logic [N-1:0] w_pc_plus4;
  logic         w_ack;

  // Sequential successor; wraps naturally at N bits
  assign w_pc_plus4 = r_pc + N'(PC_INC);

  // Request is suppressed in reset and while holding a word
  assign imem_req   = ~rst & state_requests(r_state);
  assign imem_addr  = r_pc;
  // Acks that arrive without an outstanding request are meaningless
  assign w_ack      = imem_ack & imem_req;
  assign fetch_busy = imem_req & ~imem_ack;

  assign pc_F       = r_pc;
  assign pc_plus4_F = w_pc_plus4;

  fetch_unit_register #(.W(N), .RESET_VAL(RESET_PC)) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .wen (w_pc_wen),
    .in  (w_pc_next),
    .out (r_pc)
  );

  fetch_unit_register #(.W(N), .RESET_VAL(NOP)) u_hold_reg (
    .clk (clk),
    .rst (rst),
    .wen (w_hold_wen),
    .in  (w_hold_next),
    .out (r_hold)
  );

  fetch_unit_register #(.W(N), .RESET_VAL('0)) u_redirect_reg (
    .clk (clk),
    .rst (rst),
    .wen (w_redirect_wen),
    .in  (w_redirect_next),
    .out (r_redirect)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, register updates and decode-facing outputs.
  // Redirects always outrank the decode stall.
  always_comb begin
    w_state_next    = r_state;
    w_pc_wen        = 1'b0;
    w_pc_next       = w_pc_plus4;
    w_hold_wen      = 1'b0;
    w_hold_next     = imem_rdata;
    w_redirect_wen  = 1'b0;
    w_redirect_next = branch_target_E;
    inst_F          = NOP;
    valid_F         = 1'b0;

    if (!rst) begin
      unique case (r_state)
        FETCH: begin
          if (w_ack) begin
            if (branch_taken_E) begin
              // Word is on the wrong path: drop it and refetch at the target
              w_pc_wen  = 1'b1;
              w_pc_next = branch_target_E;
            end else if (!stall_D) begin
              inst_F   = imem_rdata;
              valid_F  = 1'b1;
              w_pc_wen = 1'b1;
            end else begin
              // Decode cannot take it now: park the word, keep pc
              inst_F       = imem_rdata;
              valid_F      = 1'b1;
              w_hold_wen   = 1'b1;
              w_state_next = HOLD;
            end
          end else if (branch_taken_E) begin
            // Request can't be cancelled; remember where to go once it lands
            w_redirect_wen = 1'b1;
            w_state_next   = DISCARD;
          end
        end

        DISCARD: begin
          // A younger redirect supersedes the remembered one
          if (branch_taken_E) begin
            w_redirect_wen = 1'b1;
          end
          if (w_ack) begin
            w_pc_wen     = 1'b1;
            w_pc_next    = branch_taken_E ? branch_target_E : r_redirect;
            w_state_next = FETCH;
          end
        end

        HOLD: begin
          inst_F  = r_hold;
          valid_F = 1'b1;
          if (branch_taken_E) begin
            w_pc_wen     = 1'b1;
            w_pc_next    = branch_target_E;
            w_state_next = FETCH;
          end else if (!stall_D) begin
            w_pc_wen     = 1'b1;
            w_state_next = FETCH;
          end
        end

        default: begin
          w_state_next = FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_inst;
    logic        e_valid;
    logic        e_busy;
    logic        chk_out;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_D;
  logic        branch_taken_E;
  logic [31:0] branch_target_E;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst_F;
  logic [31:0] pc_F;
  logic [31:0] pc_plus4_F;
  logic        valid_F;
  logic        fetch_busy;

  int total = 0;
  int bad   = 0;
  int vec_no = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall_D         (stall_D),
    .branch_taken_E  (branch_taken_E),
    .branch_target_E (branch_target_E),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .inst_F          (inst_F),
    .pc_F            (pc_F),
    .pc_plus4_F      (pc_plus4_F),
    .valid_F         (valid_F),
    .fetch_busy      (fetch_busy)
  );

  function automatic vec_t mk(
    input logic rst_i, input logic stall_i, input logic br_i, input logic [31:0] tgt_i,
    input logic ack_i, input logic [31:0] rdata_i,
    input logic req_e, input logic [31:0] addr_e, input logic [31:0] inst_e,
    input logic valid_e, input logic busy_e, input logic chk_i);
    vec_t v;
    v.rst = rst_i;  v.stall = stall_i; v.br = br_i; v.tgt = tgt_i;
    v.ack = ack_i;  v.rdata = rdata_i;
    v.e_req = req_e; v.e_addr = addr_e; v.e_inst = inst_e;
    v.e_valid = valid_e; v.e_busy = busy_e; v.chk_out = chk_i;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL vec %0d %s: got %h expected %h", vec_no, name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, compare combinational outputs, let the edge pass
  task automatic apply(input vec_t v);
    logic [31:0] e_pc4;
    @(negedge clk);
    rst             = v.rst;
    stall_D         = v.stall;
    branch_taken_E  = v.br;
    branch_target_E = v.tgt;
    imem_ack        = v.ack;
    imem_rdata      = v.rdata;
    #1;
    e_pc4 = v.e_addr + 32'd4;
    check("imem_req",   {31'd0, imem_req},   {31'd0, v.e_req});
    check("imem_addr",  imem_addr,           v.e_addr);
    check("pc_F",       pc_F,                v.e_addr);
    check("pc_plus4_F", pc_plus4_F,          e_pc4);
    check("fetch_busy", {31'd0, fetch_busy}, {31'd0, v.e_busy});
    if (v.chk_out) begin
      check("inst_F",  inst_F,            v.e_inst);
      check("valid_F", {31'd0, valid_F},  {31'd0, v.e_valid});
    end
    $display("vec %0d rst=%b ack=%b br=%b stall=%b -> req=%b addr=%h inst=%h valid=%b busy=%b",
             vec_no, v.rst, v.ack, v.br, v.stall, imem_req, imem_addr, inst_F, valid_F, fetch_busy);
    vec_no++;
  endtask

  localparam logic [31:0] BAD = 32'hBAD0_BAD0;

  initial begin
    rst = 1'b1; stall_D = 1'b0; branch_taken_E = 1'b0;
    branch_target_E = '0; imem_ack = 1'b0; imem_rdata = '0;
    repeat (2) @(posedge clk);

    //           rst stl br tgt        ack rdata          req addr        inst           val bsy chk
    // reset: ack ignored, outputs quiet
    tbl.push_back(mk(1,0,0,32'h0,     1,32'hDEAD_BEEF,  0,32'h000,    32'h0,         0,0,1));
    // zero-bubble sequential fetch 0,4,8,C
    tbl.push_back(mk(0,0,0,32'h0,     1,32'h1000_0000,  1,32'h000,    32'h1000_0000, 1,0,1));
    tbl.push_back(mk(0,0,0,32'h0,     1,32'h1000_0004,  1,32'h004,    32'h1000_0004, 1,0,1));
    tbl.push_back(mk(0,0,0,32'h0,     1,32'h1000_0008,  1,32'h008,    32'h1000_0008, 1,0,1));
    tbl.push_back(mk(0,0,0,32'h0,     1,32'h1000_000C,  1,32'h00C,    32'h1000_000C, 1,0,1));
    // late ack at 0x10
    tbl.push_back(mk(0,0,0,32'h0,     0,BAD,            1,32'h010,    32'h0,         0,1,1));
    tbl.push_back(mk(0,0,0,32'h0,     0,BAD,            1,32'h010,    32'h0,         0,1,1));
    tbl.push_back(mk(0,0,0,32'h0,     1,32'h1000_0010,  1,32'h010,    32'h1000_0010, 1,0,1));
    tbl.push_back(mk(0,0,0,32'h0,     1,32'h1000_0014,  1,32'h014,    32'h1000_0014, 1,0,1));
    tbl.push_back(mk(0,0,0,32'h0,     1,32'h1000_0018,  1,32'h018,    32'h1000_0018, 1,0,1));
    tbl.push_back(mk(0,0,0,32'h0,     1,32'h1000_001C,  1,32'h01C,    32'h1000_001C, 1,0,1));
    // ack at 0x20 under stall -> HOLD; stray acks while idle ignored
    tbl.push_back(mk(0,1,0,32'h0,     1,32'h2000_0020,  1,32'h020,    32'h0,         0,0,0));
    tbl.push_back(mk(0,1,0,32'h0,     1,BAD,            0,32'h020,    32'h2000_0020, 1,0,1));
    tbl.push_back(mk(0,1,0,32'h0,     0,BAD,            0,32'h020,    32'h2000_0020, 1,0,1));
    tbl.push_back(mk(0,0,0,32'h0,     0,BAD,            0,32'h020,    32'h2000_0020, 1,0,1));
    tbl.push_back(mk(0,0,0,32'h0,     1,32'h1000_0024,  1,32'h024,    32'h1000_0024, 1,0,1));
    tbl.push_back(mk(0,0,0,32'h0,     1,32'h1000_0028,  1,32'h028,    32'h1000_0028, 1,0,1));
    tbl.push_back(mk(0,0,0,32'h0,     1,32'h1000_002C,  1,32'h02C,    32'h1000_002C, 1,0,1));
    // branch to 0x100 while 0x30 outstanding -> DISCARD
    tbl.push_back(mk(0,0,1,32'h100,   0,BAD,            1,32'h030,    32'h0,         0,1,1));
    tbl.push_back(mk(0,0,0,32'h0,     0,BAD,            1,32'h030,    32'h0,         0,1,1));
    tbl.push_back(mk(0,0,0,32'h0,     1,32'h3000_0030,  1,32'h030,    32'h0,         0,0,1));
    tbl.push_back(mk(0,0,0,32'h0,     1,32'h1000_0100,  1,32'h100,    32'h1000_0100, 1,0,1));
    // branch to 0x200 from HOLD
    tbl.push_back(mk(0,1,0,32'h0,     1,32'h4000_0104,  1,32'h104,    32'h0,         0,0,0));
    tbl.push_back(mk(0,1,1,32'h200,   0,BAD,            0,32'h104,    32'h4000_0104, 1,0,1));
    tbl.push_back(mk(0,1,0,32'h0,     0,BAD,            1,32'h200,    32'h0,         0,1,1));
    tbl.push_back(mk(0,0,0,32'h0,     1,32'h1000_0200,  1,32'h200,    32'h1000_0200, 1,0,1));
    // branch coincident with ack in FETCH
    tbl.push_back(mk(0,0,1,32'h300,   1,32'h5000_0204,  1,32'h204,    32'h0,         0,0,1));
    // DISCARD with a younger redirect overwriting the older one
    tbl.push_back(mk(0,0,1,32'h400,   0,BAD,            1,32'h300,    32'h0,         0,1,1));
    tbl.push_back(mk(0,0,1,32'h500,   0,BAD,            1,32'h300,    32'h0,         0,1,1));
    tbl.push_back(mk(0,0,0,32'h0,     1,32'h6000_0300,  1,32'h300,    32'h0,         0,0,1));
    tbl.push_back(mk(0,0,0,32'h0,     1,32'h1000_0500,  1,32'h500,    32'h1000_0500, 1,0,1));
    // DISCARD where the ack cycle carries its own branch
    tbl.push_back(mk(0,0,1,32'h600,   0,BAD,            1,32'h504,    32'h0,         0,1,1));
    tbl.push_back(mk(0,0,1,32'h700,   1,32'h7000_0504,  1,32'h504,    32'h0,         0,0,1));
    tbl.push_back(mk(0,0,0,32'h0,     0,BAD,            1,32'h700,    32'h0,         0,1,1));

    foreach (tbl[i]) apply(tbl[i]);

    // Hand sequence: pc wrap at the top of the address space
    apply(mk(0,0,1,32'hFFFF_FFFC,1,32'h5000_0700,  1,32'h700,       32'h0,         0,0,1));
    apply(mk(0,0,0,32'h0,        1,32'h8000_FFFC,  1,32'hFFFF_FFFC, 32'h8000_FFFC, 1,0,1));
    apply(mk(0,0,0,32'h0,        1,32'h1000_0000,  1,32'h000,       32'h1000_0000, 1,0,1));

    // Hand sequence: reset during DISCARD with an ack landing in reset
    apply(mk(0,0,1,32'h800,      0,BAD,            1,32'h004,       32'h0,         0,1,1));
    apply(mk(1,0,0,32'h0,        1,BAD,            0,32'h004,       32'h0,         0,0,1));
    apply(mk(0,0,0,32'h0,        0,BAD,            1,32'h000,       32'h0,         0,1,1));
    apply(mk(0,0,0,32'h0,        1,32'h1000_0000,  1,32'h000,       32'h1000_0000, 1,0,1));
    apply(mk(0,0,0,32'h0,        0,BAD,            1,32'h004,       32'h0,         0,1,1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
